regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
Controller in front of the 32-entry register file that shares its single write port and read port 1.
- Write-port clients: ALU writeback (wb0), load writeback (wb1), and a debug access channel.
- Write arbitration: fixed priority with anti-starvation for wb1.
- Debug accesses are sequenced by a small FSM that steals the write port or read port 1 and stalls the CPU while it does.

Parameters:
- XW, 32, register/data width in bits.
- STARVE_MAX, 4, consecutive denied cycles of wb1 before it is force-granted (1..15).
- CNT_W, 16, width of the optional conflict counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_wb0_valid  in  1  ALU writeback request
- i_wb0_addr  in  5  ALU destination register
- i_wb0_data  in  XW  ALU writeback data
- o_wb0_ready  out  1  wb0 accepted this cycle
- i_wb1_valid  in  1  load writeback request
- i_wb1_addr  in  5  load destination register
- i_wb1_data  in  XW  load writeback data
- o_wb1_ready  out  1  wb1 accepted this cycle
- i_dbg_req  in  1  debug access request (level, held until ack)
- i_dbg_we  in  1  1=write, 0=read; sampled with req
- i_dbg_addr  in  5  debug register index
- i_dbg_wdata  in  XW  debug write data
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_rdata  out  XW  debug read result, valid with ack, held after
- i_cpu_rd_addr1  in  5  decode read address 1
- o_rf_rd_addr1  out  5  to regfile read port 1
- i_rf_rd_data1  in  XW  from regfile read port 1
- o_cpu_stall  out  1  CPU must hold pipeline
- o_rf_wr_en  out  1  to regfile write enable
- o_rf_wr_addr  out  5  to regfile write address
- o_rf_wr_data  out  XW  to regfile write data

Reset is i_rst_n, asynchronous, active-low; the clock is i_clk.

Behaviour:
- Reset values:
  - All registered outputs are 0: o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_dbg_ack, o_dbg_rdata.
  - FSM is in IDLE and the starvation counter is 0.
  - o_cpu_stall is 0 and o_rf_rd_addr1 = i_cpu_rd_addr1 (both combinational from FSM state).
- Grant is combinational each cycle, in this order:
  - Debug write: FSM in DBG_WR owns the port.
  - Otherwise wb1, if i_wb1_valid and starve_cnt == STARVE_MAX.
  - Otherwise wb0, if i_wb0_valid.
  - Otherwise wb1, if i_wb1_valid.
- Ready/valid rules:
  - o_wbN_ready = grant to N; a transfer occurs on valid & ready.
  - Ready never depends on the requester's own data.
  - Requesters hold valid, addr and data stable until ready.
- Write path latency:
  - The granted transfer is registered and appears on o_rf_wr_* the next cycle; o_rf_wr_en is high for exactly 1 cycle per transfer.
  - Data reaches the regfile array 2 edges after acceptance.
  - A transfer with addr 0 is accepted (ready=1) but drives o_rf_wr_en=0.
- Starvation counter:
  - Increments when i_wb1_valid & ~o_wb1_ready and saturates at STARVE_MAX.
  - Clears when wb1 is granted or i_wb1_valid=0.
- Debug FSM states: IDLE, DBG_WR, DBG_RD, DBG_RDW, DBG_ACK, DBG_DONE.
  - IDLE: on i_dbg_req, latch we/addr/wdata; go to DBG_WR if we, else DBG_RD.
  - DBG_WR (1 cycle): o_cpu_stall=1, both wb ready=0, write is issued as a normal transfer; go to DBG_ACK.
  - DBG_RD (1 cycle): o_cpu_stall=1, o_rf_rd_addr1 = latched addr, wb arbitration continues normally; go to DBG_RDW.
  - DBG_RDW: o_cpu_stall=1; capture i_rf_rd_data1 into o_dbg_rdata (addr 0 reads 0 via the regfile); go to DBG_ACK.
  - DBG_ACK: o_dbg_ack=1 for one cycle; go to DBG_DONE.
  - DBG_DONE: wait for i_dbg_req=0, then go to IDLE. A request still held after ack never retriggers.
- Simultaneous events:
  - A debug write entering DBG_WR blocks wb0/wb1 for that cycle only; it does not bump starve_cnt.
  - A debug read does not block writes, so a wb write to the same register in DBG_RD returns the pre-write value (regfile has no bypass).
- Reset mid-operation: FSM returns to IDLE with no ack, and any registered write is dropped (o_rf_wr_en=0).

Optional Feature:
Macro REGFILE_WR_ARBITER_PERF_EN.
- Defined: adds output o_conflict_cnt [CNT_W-1:0], reset 0. It increments by 1 every cycle in which i_wb0_valid & i_wb1_valid, or in which any wb valid is blocked by DBG_WR. It saturates at all-ones.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then wb0 valid addr 5 data 0xDEADBEEF -> wb0_ready same cycle; o_rf_wr_en=1, addr 5, data 0xDEADBEEF next cycle; a read of x5 two cycles later returns 0xDEADBEEF.
2. wb0 and wb1 both valid continuously, STARVE_MAX=4 -> wb0 granted 4 cycles, wb1 granted on cycle 5, then the pattern repeats; with PERF_EN, o_conflict_cnt = 10 after 10 cycles.
3. wb1 valid addr 0 data 0x1234 -> wb1_ready=1, o_rf_wr_en stays 0; a read of x0 returns 0.
4. Debug write addr 7 data 0xA5A5A5A5 while wb0 valid -> wb0_ready=0 and stall=1 for 1 cycle; wb0 granted the following cycle; ack pulses once; a debug read of x7 returns 0xA5A5A5A5.
5. Debug read addr 3 (x3 = 0x55) with i_dbg_req held 10 cycles -> stall for 2 cycles; o_rf_rd_addr1=3 in DBG_RD; exactly one ack with o_dbg_rdata=0x55; no second access until req drops.
6. Assert i_rst_n=0 during DBG_RDW -> stall and ack are 0 immediately; after release the FSM is in IDLE and o_rf_wr_en=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port / read port 1 among wb0, wb1 and a debug FSM (REGFILE_WR_ARBITER_PERF_EN adds a conflict counter).
// Latency: accepted write appears on o_rf_wr_* one cycle later; debug read acks 3 cycles after request, debug write 2.
// Backpressure: wbN_ready is the combinational grant; wb1 is force-granted after STARVE_MAX denials; DBG_WR blocks both.
module regfile_wr_arbiter #(
    parameter int XW         = 32,
    parameter int STARVE_MAX = 4
`ifdef REGFILE_WR_ARBITER_PERF_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb0_valid,
    input  logic [4:0]    i_wb0_addr,
    input  logic [XW-1:0] i_wb0_data,
    output logic          o_wb0_ready,
    input  logic          i_wb1_valid,
    input  logic [4:0]    i_wb1_addr,
    input  logic [XW-1:0] i_wb1_data,
    output logic          o_wb1_ready,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic [4:0]    i_dbg_addr,
    input  logic [XW-1:0] i_dbg_wdata,
    output logic          o_dbg_ack,
    output logic [XW-1:0] o_dbg_rdata,
    input  logic [4:0]    i_cpu_rd_addr1,
    output logic [4:0]    o_rf_rd_addr1,
    input  logic [XW-1:0] i_rf_rd_data1,
    output logic          o_cpu_stall,
    output logic          o_rf_wr_en,
    output logic [4:0]    o_rf_wr_addr,
    output logic [XW-1:0] o_rf_wr_data
`ifdef REGFILE_WR_ARBITER_PERF_EN
    ,
    output logic [CNT_W-1:0] o_conflict_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, DBG_WR, DBG_RD, DBG_RDW, DBG_ACK, DBG_DONE
    } state_t;

    state_t          state_q, state_nxt;
    logic [4:0]      dbg_addr_q;
    logic [XW-1:0]   dbg_wdata_q;
    logic [3:0]      starve_q;
    logic            gnt_dbg, gnt_wb0, gnt_wb1, xfer_vld;
    logic [4:0]      xfer_addr;
    logic [XW-1:0]   xfer_data;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:     if (i_dbg_req) state_nxt = i_dbg_we ? DBG_WR : DBG_RD;
            DBG_WR:   state_nxt = DBG_ACK;
            DBG_RD:   state_nxt = DBG_RDW;
            DBG_RDW:  state_nxt = DBG_ACK;
            DBG_ACK:  state_nxt = DBG_DONE;
            DBG_DONE: if (!i_dbg_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign o_cpu_stall   = (state_q == DBG_WR) || (state_q == DBG_RD) || (state_q == DBG_RDW);
    assign o_rf_rd_addr1 = (state_q == DBG_RD) ? dbg_addr_q : i_cpu_rd_addr1;

    // Starvation override sits above wb0 but below an in-flight debug write.
    always_comb begin
        gnt_dbg   = (state_q == DBG_WR);
        gnt_wb0   = 1'b0;
        gnt_wb1   = 1'b0;
        xfer_addr = i_wb0_addr;
        xfer_data = i_wb0_data;
        if (!gnt_dbg) begin
            if (i_wb1_valid && (starve_q == 4'(STARVE_MAX))) gnt_wb1 = 1'b1;
            else if (i_wb0_valid)                            gnt_wb0 = 1'b1;
            else if (i_wb1_valid)                            gnt_wb1 = 1'b1;
        end
        if (gnt_dbg) begin
            xfer_addr = dbg_addr_q;
            xfer_data = dbg_wdata_q;
        end else if (gnt_wb1) begin
            xfer_addr = i_wb1_addr;
            xfer_data = i_wb1_data;
        end
    end

    assign o_wb0_ready = gnt_wb0;
    assign o_wb1_ready = gnt_wb1;
    assign xfer_vld    = gnt_dbg | gnt_wb0 | gnt_wb1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            dbg_addr_q   <= '0;
            dbg_wdata_q  <= '0;
            starve_q     <= '0;
            o_rf_wr_en   <= 1'b0;
            o_rf_wr_addr <= '0;
            o_rf_wr_data <= '0;
            o_dbg_ack    <= 1'b0;
            o_dbg_rdata  <= '0;
        end else begin
            state_q   <= state_nxt;
            o_dbg_ack <= (state_nxt == DBG_ACK);
            if (state_q == IDLE && i_dbg_req) begin
                dbg_addr_q  <= i_dbg_addr;
                dbg_wdata_q <= i_dbg_wdata;
            end
            if (state_q == DBG_RDW) o_dbg_rdata <= i_rf_rd_data1;
            // A debug-write stall freezes the count rather than charging wb1.
            if (!i_wb1_valid || gnt_wb1)                  starve_q <= '0;
            else if (!gnt_dbg && starve_q != 4'(STARVE_MAX)) starve_q <= starve_q + 4'd1;
            // x0 writes are accepted but never reach the array.
            o_rf_wr_en <= xfer_vld && (xfer_addr != 5'd0);
            if (xfer_vld) begin
                o_rf_wr_addr <= xfer_addr;
                o_rf_wr_data <= xfer_data;
            end
        end
    end

`ifdef REGFILE_WR_ARBITER_PERF_EN
    logic conflict;
    assign conflict = (i_wb0_valid && i_wb1_valid) || (gnt_dbg && (i_wb0_valid || i_wb1_valid));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                           o_conflict_cnt <= '0;
        else if (conflict && !(&o_conflict_cnt)) o_conflict_cnt <= o_conflict_cnt + 1'b1;
    end
`endif

endmodule
